uart_prog_loader: RTL and testbench

User-project block that receives the program image sent over the UART programming pin (mprj_io[5]), deframes 8N1 serial bytes, packs them little-endian into 32-bit words and writes them into the FPU core's instruction memory. It asserts a sticky done flag, driven out on mprj_io[37], once the end-of-image word arrives. The core is released from its load phase by that flag. It is the on-chip receiving end of the bench's UART programmer.

---
 rtl/uart_prog_loader.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART (8N1, or 8E1 when UART_LOADER_PARITY_EN is defined) program loader: deframes bytes,
// packs them little-endian into 32-bit words and writes them to instruction memory until END_WORD.
module uart_prog_loader #(
    parameter int          CLKS_PER_BIT = 4167,
    parameter int          ADDR_W       = 10,
    parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              prog_done_o,
    output logic              frame_err_o,
    output logic              parity_err_o
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_LOADER_PARITY_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3,
        RECOVER = 3'd4, DONE  = 3'd5, PARITY = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3,
        RECOVER = 3'd4, DONE  = 3'd5
    } state_t;
`endif

    // Even parity: data bits plus parity bit must XOR to zero.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return (^{data, par}) == 1'b0;
    endfunction

    state_t            state_r, state_next_s;
    logic              rx_meta_r, rx_s_r;
    logic [TW-1:0]     timer_r;
    logic [2:0]        bit_idx_r;
    logic [7:0]        shift_r;
    logic [1:0]        byte_cnt_r;
    logic [23:0]       word_buf_r;
    logic [ADDR_W-1:0] word_cnt_r;
    logic              timer_clr_s, sample_bit_s, byte_ok_s, frame_err_set_s;
    logic              byte_good_s;
    logic [31:0]       word_s;
`ifdef UART_LOADER_PARITY_EN
    logic              par_check_s, parity_bad_r, parity_err_r;
    assign byte_good_s  = ~parity_bad_r;
    assign parity_err_o = parity_err_r;
`else
    assign byte_good_s  = 1'b1;
    assign parity_err_o = 1'b0;
`endif

    assign word_s = {shift_r, word_buf_r};

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_s_r    <= 1'b1;
        end else begin
            rx_meta_r <= rx_i;
            rx_s_r    <= rx_meta_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and datapath enables.
    always_comb begin
        state_next_s    = state_r;
        timer_clr_s     = 1'b0;
        sample_bit_s    = 1'b0;
        byte_ok_s       = 1'b0;
        frame_err_set_s = 1'b0;
`ifdef UART_LOADER_PARITY_EN
        par_check_s     = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (!rx_s_r) begin
                    state_next_s = START;
                    timer_clr_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (timer_r == HALF_END) begin
                    timer_clr_s  = 1'b1;
                    state_next_s = rx_s_r ? IDLE : DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (timer_r == BIT_END) begin
                    timer_clr_s  = 1'b1;
                    sample_bit_s = 1'b1;
`ifdef UART_LOADER_PARITY_EN
                    state_next_s = (bit_idx_r == 3'd7) ? PARITY : DATA;
`else
                    state_next_s = (bit_idx_r == 3'd7) ? STOP : DATA;
`endif
                end else begin
                    state_next_s = DATA;
                end
            end
`ifdef UART_LOADER_PARITY_EN
            PARITY: begin
                if (timer_r == BIT_END) begin
                    timer_clr_s  = 1'b1;
                    par_check_s  = 1'b1;
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (timer_r == BIT_END) begin
                    timer_clr_s = 1'b1;
                    if (rx_s_r) begin
                        byte_ok_s = byte_good_s;
                        // Terminator is only recognised on a complete, valid word.
                        if (byte_good_s && (byte_cnt_r == 2'd3) && (word_s == END_WORD)) begin
                            state_next_s = DONE;
                        end else begin
                            state_next_s = IDLE;
                        end
                    end else begin
                        frame_err_set_s = 1'b1;
                        state_next_s    = RECOVER;
                    end
                end else begin
                    state_next_s = STOP;
                end
            end
            RECOVER: begin
                state_next_s = rx_s_r ? IDLE : RECOVER;
            end
            DONE: begin
                state_next_s = DONE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Bit timing, byte assembly, word packing and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_r      <= '0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'd0;
            byte_cnt_r   <= 2'd0;
            word_buf_r   <= 24'd0;
            word_cnt_r   <= '0;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= '0;
            imem_wdata_o <= 32'd0;
            prog_done_o  <= 1'b0;
            frame_err_o  <= 1'b0;
`ifdef UART_LOADER_PARITY_EN
            parity_bad_r <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            imem_we_o <= 1'b0;
            timer_r   <= timer_clr_s ? '0 : timer_r + TW'(1);
            if (state_r == START) begin
                bit_idx_r <= 3'd0;
            end else if (sample_bit_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end
            if (sample_bit_s) begin
                shift_r <= {rx_s_r, shift_r[7:1]};
            end
`ifdef UART_LOADER_PARITY_EN
            if (state_r == START) begin
                parity_bad_r <= 1'b0;
            end else if (par_check_s) begin
                parity_bad_r <= ~parity_ok(shift_r, rx_s_r);
                if (!parity_ok(shift_r, rx_s_r)) begin
                    parity_err_r <= 1'b1;
                end
            end
`endif
            if (frame_err_set_s) begin
                frame_err_o <= 1'b1;
            end
            if (byte_ok_s) begin
                if (byte_cnt_r == 2'd3) begin
                    byte_cnt_r <= 2'd0;
                    if (word_s == END_WORD) begin
                        prog_done_o <= 1'b1;
                    end else begin
                        imem_we_o    <= 1'b1;
                        imem_addr_o  <= word_cnt_r;
                        imem_wdata_o <= word_s;
                        word_cnt_r   <= word_cnt_r + ADDR_W'(1);
                    end
                end else begin
                    word_buf_r[{byte_cnt_r, 3'b000} +: 8] <= shift_r;
                    byte_cnt_r <= byte_cnt_r + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: expected writes are queued as bytes are sent and
// checked when imem_we_o strobes.
module tb_uart_prog_loader;

    localparam int CPB    = 8;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_i = 1'b1;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_wdata_o;
    logic              prog_done_o;
    logic              frame_err_o;
    logic              parity_err_o;

    int vectors = 0;
    int miscompares = 0;
    logic [ADDR_W+31:0] exp_q[$];
    logic prev_we = 1'b0;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .END_WORD(32'h0000_0FFF)) dut (
        .clk(clk), .rst_n(rst_n), .rx_i(rx_i),
        .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
        .prog_done_o(prog_done_o), .frame_err_o(frame_err_o), .parity_err_o(parity_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (imem_we_o) begin
            check("we_single_cycle", {31'd0, prev_we}, 32'd0);
            check("write_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                check("imem_addr", 32'(imem_addr_o), 32'(e[ADDR_W+31:32]));
                check("imem_wdata", imem_wdata_o, e[31:0]);
            end
        end
        prev_we = imem_we_o;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        idle(CPB);
    endtask

    task automatic send_byte_raw(input logic [7:0] b, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_LOADER_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
        rx_i = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_byte_raw(b, ^b, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] w);
        exp_q.push_back({a, w});
    endtask

    task automatic check_drained(input string tag);
        idle(4 * CPB);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_we"}, {31'd0, imem_we_o}, 32'd0);
        check({tag, "_addr"}, 32'(imem_addr_o), 32'd0);
        check({tag, "_wdata"}, imem_wdata_o, 32'd0);
        check({tag, "_done"}, {31'd0, prog_done_o}, 32'd0);
        check({tag, "_ferr"}, {31'd0, frame_err_o}, 32'd0);
        check({tag, "_perr"}, {31'd0, parity_err_o}, 32'd0);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        idle(n);
        rst_n = 1'b1;
        exp_q.delete();
        idle(2);
    endtask

    initial begin
        rx_i = 1'b1;
        rst_n = 1'b0;
        idle(4);
        rst_n = 1'b1;
        idle(2);
        check_reset("reset");

        // Basic word and address increment, back-to-back bytes.
        expect_write(2'd0, 32'h0050_0513);
        send_word(32'h0050_0513);
        expect_write(2'd1, 32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF);
        check_drained("two_words");
        check("addr_hold", 32'(imem_addr_o), 32'd1);
        check("wdata_hold", imem_wdata_o, 32'hDEAD_BEEF);

        // Stop bit low: byte discarded, sticky frame error, alignment unchanged.
        send_byte_raw(8'hA5, ^(8'hA5), 1'b0);
        idle(2 * CPB);
        check("frame_err", {31'd0, frame_err_o}, 32'd1);
        expect_write(2'd2, 32'h1234_5678);
        send_word(32'h1234_5678);
        check_drained("after_frame_err");

        // Short low glitch while idle must not start a byte.
        rx_i = 1'b0;
        idle(3);
        rx_i = 1'b1;
        idle(3 * CPB);
        expect_write(2'd3, 32'hCAFE_F00D);
        send_word(32'hCAFE_F00D);
        check_drained("after_glitch");
        check("frame_err_sticky", {31'd0, frame_err_o}, 32'd1);

        // Address wraps to 0.
        expect_write(2'd0, 32'h0BAD_C0DE);
        send_word(32'h0BAD_C0DE);
        check_drained("wrap");

        // Terminator: no write, done sticky, further input ignored.
        check("done_before_term", {31'd0, prog_done_o}, 32'd0);
        send_word(32'h0000_0FFF);
        idle(2);
        check("prog_done", {31'd0, prog_done_o}, 32'd1);
        send_word(32'h1122_3344);
        check_drained("after_done");
        check("prog_done_held", {31'd0, prog_done_o}, 32'd1);

        // One-cycle reset clears everything.
        pulse_reset(1);
        check_reset("reset_after_done");

        // Reset mid-word discards the partial bytes.
        send_byte(8'hAA);
        send_byte(8'hBB);
        pulse_reset(1);
        check_reset("reset_mid_word");
        expect_write(2'd0, 32'h4433_2211);
        send_word(32'h4433_2211);
        check_drained("fresh_after_reset");

`ifdef UART_LOADER_PARITY_EN
        pulse_reset(1);
        send_byte_raw(8'h07, 1'b0, 1'b1);
        idle(2 * CPB);
        check("parity_err", {31'd0, parity_err_o}, 32'd1);
        expect_write(2'd0, 32'h0302_0107);
        send_byte_raw(8'h07, 1'b1, 1'b1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check_drained("after_parity_err");
        check("parity_err_sticky", {31'd0, parity_err_o}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
